dac_tx_packer: RTL and testbench



---
 rtl/dac_tx_packer.sv | 179 +++++++++++++++++
 tb/tb_dac_tx_packer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_tx_packer.sv
// Packs per-DAC I/Q sample vectors into one JESD204 transmit word, with a
// ready-driven IDLE/WARMUP/RUN sequencer, test-pattern sources and link-loss counters.
module dac_tx_packer #(
  parameter int NUM_DAC   = 2,
  parameter int NUM_CH    = 4,
  parameter int SAMPLE_W  = 16,
  parameter int BYTE_SWAP = 1,
  parameter int DAC_SWAP  = 1,
  parameter int WARM_CYC  = 16
) (
  input  logic                                  clk_user_bufg,
  input  logic                                  rst,
  input  logic                                  dac_ready,
  input  logic [1:0]                            mode,
  input  logic [NUM_DAC*NUM_CH*SAMPLE_W-1:0]    din_i,
  input  logic [NUM_DAC*NUM_CH*SAMPLE_W-1:0]    din_q,
  input  logic                                  din_valid,
  input  logic [2*SAMPLE_W-1:0]                 tp_word,
  output logic [2*NUM_DAC*NUM_CH*SAMPLE_W-1:0]  dac_tx_tdata,
  output logic                                  tdata_run,
  output logic                                  dac_ready_negedge,
  output logic [15:0]                           lose_cnt,
  output logic [15:0]                           underrun_cnt,
  output logic [1:0]                            state_o
);

  localparam int TW     = 2 * NUM_DAC * NUM_CH * SAMPLE_W;
  localparam int SLOT_W = 2 * NUM_CH * SAMPLE_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [15:0] WARM_LAST = 16'(WARM_CYC - 1);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [15:0]         warm_cnt_r;
  logic [SAMPLE_W-1:0] ramp_base_r;
  logic [TW-1:0]       word_s;
  logic [TW-1:0]       s1_word_r;
  logic                s1_run_r;
  logic                ready_d_r;
  logic [SAMPLE_W-1:0] smp_i_s;
  logic [SAMPLE_W-1:0] smp_q_s;

  function automatic logic [SAMPLE_W-1:0] byte_swap(input logic [SAMPLE_W-1:0] v);
    logic [SAMPLE_W-1:0] r;
    r = '0;
    for (int b = 0; b < SAMPLE_W / 8; b++) begin
      r[b*8 +: 8] = v[SAMPLE_W-8-b*8 +: 8];
    end
    return r;
  endfunction

  assign state_o = state_r;

  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (dac_ready) state_nxt_s = ST_WARMUP;
        else           state_nxt_s = ST_IDLE;
      end
      ST_WARMUP: begin
        if (!dac_ready)                 state_nxt_s = ST_IDLE;
        else if (warm_cnt_r == WARM_LAST) state_nxt_s = ST_RUN;
        else                            state_nxt_s = ST_WARMUP;
      end
      ST_RUN: begin
        if (!dac_ready) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Ramp base is n*NUM_CH for beat n; it restarts whenever RUN is left.
  always_ff @(posedge clk_user_bufg) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      warm_cnt_r  <= 16'd0;
      ramp_base_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_WARMUP && state_nxt_s == ST_WARMUP) warm_cnt_r <= warm_cnt_r + 16'd1;
      else                                                  warm_cnt_r <= 16'd0;
      if (state_r == ST_RUN) ramp_base_r <= ramp_base_r + SAMPLE_W'(NUM_CH);
      else                   ramp_base_r <= '0;
    end
  end

  always_comb begin
    word_s  = '0;
    smp_i_s = '0;
    smp_q_s = '0;
    if (state_r == ST_RUN) begin
      for (int d = 0; d < NUM_DAC; d++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          case (mode)
            2'd0: begin
              if (din_valid) begin
                smp_i_s = din_i[(d*NUM_CH+c)*SAMPLE_W +: SAMPLE_W];
                smp_q_s = din_q[(d*NUM_CH+c)*SAMPLE_W +: SAMPLE_W];
              end else begin
                smp_i_s = '0;
                smp_q_s = '0;
              end
            end
            2'd1: begin
              smp_i_s = tp_word[SAMPLE_W-1:0];
              smp_q_s = tp_word[2*SAMPLE_W-1:SAMPLE_W];
            end
            2'd2: begin
              smp_i_s = ramp_base_r + SAMPLE_W'(c);
              smp_q_s = ramp_base_r + SAMPLE_W'(c);
            end
            default: begin
              smp_i_s = '0;
              smp_q_s = '0;
            end
          endcase
          if (BYTE_SWAP != 0) begin
            smp_i_s = byte_swap(smp_i_s);
            smp_q_s = byte_swap(smp_q_s);
          end else begin
            smp_i_s = smp_i_s;
            smp_q_s = smp_q_s;
          end
          // Slot order is reversed when DAC_SWAP is set.
          if (DAC_SWAP != 0) begin
            word_s[(NUM_DAC-1-d)*SLOT_W + c*2*SAMPLE_W +: SAMPLE_W]            = smp_i_s;
            word_s[(NUM_DAC-1-d)*SLOT_W + c*2*SAMPLE_W + SAMPLE_W +: SAMPLE_W] = smp_q_s;
          end else begin
            word_s[d*SLOT_W + c*2*SAMPLE_W +: SAMPLE_W]            = smp_i_s;
            word_s[d*SLOT_W + c*2*SAMPLE_W + SAMPLE_W +: SAMPLE_W] = smp_q_s;
          end
        end
      end
    end else begin
      word_s = '0;
    end
  end

  // Two-stage output pipeline; both stages clear on reset.
  always_ff @(posedge clk_user_bufg) begin
    if (rst) begin
      s1_word_r    <= '0;
      s1_run_r     <= 1'b0;
      dac_tx_tdata <= '0;
      tdata_run    <= 1'b0;
    end else begin
      s1_word_r    <= word_s;
      s1_run_r     <= (state_r == ST_RUN);
      dac_tx_tdata <= s1_word_r;
      tdata_run    <= s1_run_r;
    end
  end

  // Link-loss edge detect and saturating status counters.
  always_ff @(posedge clk_user_bufg) begin
    if (rst) begin
      ready_d_r         <= 1'b0;
      dac_ready_negedge <= 1'b0;
      lose_cnt          <= 16'd0;
      underrun_cnt      <= 16'd0;
    end else begin
      ready_d_r         <= dac_ready;
      dac_ready_negedge <= ready_d_r & ~dac_ready;
      if (ready_d_r && !dac_ready && lose_cnt != 16'hFFFF) lose_cnt <= lose_cnt + 16'd1;
      else                                                 lose_cnt <= lose_cnt;
      if (state_r == ST_RUN && mode == 2'd0 && !din_valid && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
      else
        underrun_cnt <= underrun_cnt;
    end
  end

endmodule

// File: tb/tb_dac_tx_packer.sv
// Scoreboard bench: a reference model predicts each beat when stimulus is applied,
// and the prediction is compared two clocks later against two differently-parameterised packers.
module tb_dac_tx_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         dac_ready;
  logic [1:0]   mode;
  logic [127:0] din_i;
  logic [127:0] din_q;
  logic         din_valid;
  logic [31:0]  tp_word;

  logic [255:0] tdata_a, tdata_b;
  logic         run_a, run_b, neg_a, neg_b;
  logic [15:0]  lose_a, lose_b, under_a, under_b;
  logic [1:0]   state_a, state_b;

  dac_tx_packer dut_a (
    .clk_user_bufg(clk), .rst(rst), .dac_ready(dac_ready), .mode(mode),
    .din_i(din_i), .din_q(din_q), .din_valid(din_valid), .tp_word(tp_word),
    .dac_tx_tdata(tdata_a), .tdata_run(run_a), .dac_ready_negedge(neg_a),
    .lose_cnt(lose_a), .underrun_cnt(under_a), .state_o(state_a)
  );

  dac_tx_packer #(.NUM_DAC(4), .NUM_CH(2), .DAC_SWAP(0), .BYTE_SWAP(0)) dut_b (
    .clk_user_bufg(clk), .rst(rst), .dac_ready(dac_ready), .mode(mode),
    .din_i(din_i), .din_q(din_q), .din_valid(din_valid), .tp_word(tp_word),
    .dac_tx_tdata(tdata_b), .tdata_run(run_b), .dac_ready_negedge(neg_b),
    .lose_cnt(lose_b), .underrun_cnt(under_b), .state_o(state_b)
  );

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic         run;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int          m_state = 0;
  int          m_warm  = 0;
  int          m_beat  = 0;
  logic        m_ready_d = 1'b0;
  logic        m_pulse = 1'b0;
  logic [15:0] m_lose  = 16'd0;
  logic [15:0] m_under = 16'd0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_word(input int nd, input int nch, input bit dswap,
                                              input bit bswap, input bit run);
    logic [255:0] w;
    logic [15:0]  si, sq;
    int           s, base;
    w = '0;
    if (run) begin
      for (int d = 0; d < nd; d++) begin
        for (int c = 0; c < nch; c++) begin
          case (mode)
            2'd0: begin
              si = din_valid ? din_i[(d*nch+c)*16 +: 16] : 16'd0;
              sq = din_valid ? din_q[(d*nch+c)*16 +: 16] : 16'd0;
            end
            2'd1: begin si = tp_word[15:0]; sq = tp_word[31:16]; end
            2'd2: begin si = 16'(m_beat*nch + c); sq = si; end
            default: begin si = 16'd0; sq = 16'd0; end
          endcase
          if (bswap) begin
            si = {si[7:0], si[15:8]};
            sq = {sq[7:0], sq[15:8]};
          end
          s    = dswap ? (nd - 1 - d) : d;
          base = s*2*nch*16 + c*32;
          w[base +: 16]      = si;
          w[base + 16 +: 16] = sq;
        end
      end
    end
    return w;
  endfunction

  task automatic step();
    exp_t e;
    exp_t z;
    bit   run;
    z.a = '0; z.b = '0; z.run = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(z);
      exp_q.push_back(z);
      m_state = 0; m_warm = 0; m_beat = 0;
      m_ready_d = 1'b0; m_pulse = 1'b0; m_lose = 16'd0; m_under = 16'd0;
    end else begin
      run   = (m_state == 2);
      e.run = run;
      e.a   = model_word(2, 4, 1'b1, 1'b1, run);
      e.b   = model_word(4, 2, 1'b0, 1'b0, run);
      exp_q.push_back(e);
      m_pulse = m_ready_d & ~dac_ready;
      if (m_pulse && m_lose != 16'hFFFF) m_lose++;
      if (run && mode == 2'd0 && !din_valid && m_under != 16'hFFFF) m_under++;
      m_beat = run ? (m_beat + 1) : 0;
      case (m_state)
        0: if (dac_ready) begin m_state = 1; m_warm = 0; end
        1: if (!dac_ready) m_state = 0;
           else if (m_warm == 15) m_state = 2;
           else m_warm++;
        default: if (!dac_ready) m_state = 0;
      endcase
      m_ready_d = dac_ready;
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 256'd1, 256'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("tdata_a", tdata_a, e.a);
      check_val("tdata_b", tdata_b, e.b);
      check_val("run_a", 256'(run_a), 256'(e.run));
      check_val("run_b", 256'(run_b), 256'(e.run));
    end
    check_val("state", 256'(state_a), 256'(m_state));
    check_val("negedge", 256'(neg_a), 256'(m_pulse));
    check_val("lose_cnt", 256'(lose_a), 256'(m_lose));
    check_val("underrun_cnt", 256'(under_a), 256'(m_under));
  endtask

  task automatic new_din();
    for (int i = 0; i < 4; i++) begin
      din_i[i*32 +: 32] = $urandom;
      din_q[i*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1; dac_ready = 1'b0; mode = 2'd0; din_valid = 1'b1; tp_word = 32'h0;
    new_din();
    repeat (3) step();
    rst = 1'b0;
    repeat (9) step();

    // Mode 0 bring-up with a marker sample on DAC0 sample 0.
    din_i[15:0] = 16'h1234;
    dac_ready = 1'b1;
    repeat (20) step();
    check_val("dac0_s0_swapped", 256'(tdata_a[143:128]), 256'(16'h3412));
    check_val("run_after_warmup", 256'(run_a), 256'd1);
    check_val("b_dac3_s1_q", 256'(tdata_b[255:240]), 256'(din_q[7*16 +: 16]));

    for (int i = 0; i < 10; i++) begin
      new_din();
      step();
    end
    din_valid = 1'b0;
    repeat (5) step();
    check_val("underrun_5", 256'(under_a), 256'd5);
    din_valid = 1'b1;

    mode = 2'd1; tp_word = 32'h7FFF7FFF;
    repeat (3) step();
    for (int l = 0; l < 8; l++) begin
      check_val("tp_lane", 256'(tdata_a[l*32 +: 32]), 256'(32'hFF7FFF7F));
    end
    mode = 2'd3;
    repeat (3) step();

    // Link loss in RUN, then re-entry directly into ramp mode.
    dac_ready = 1'b0;
    step();
    check_val("loss_pulse", 256'(neg_a), 256'd1);
    check_val("loss_count", 256'(lose_a), 256'd1);
    mode = 2'd2;
    dac_ready = 1'b1;
    repeat (17 + 2 + 16385) step();

    mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      new_din();
      din_valid = 1'($urandom_range(0, 1));
      step();
    end
    din_valid = 1'b1;

    for (int i = 0; i < 20; i++) begin
      dac_ready = 1'b0;
      step();
      dac_ready = 1'b1;
      step();
    end
    check_val("lose_21", 256'(lose_a), 256'd21);

    repeat (20) step();
    rst = 1'b1;
    step();
    check_val("rst_tdata_zero", tdata_a, 256'd0);
    check_val("rst_run_zero", 256'(run_a), 256'd0);
    step();
    rst = 1'b0;
    repeat (5) step();
    check_val("no_pulse_after_rst", 256'(neg_a), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
